// File: rtl/dbg_scan_pkg.sv
// Shared types and constants for the debug memory-dump scanner.
package dbg_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        PUB  = 2'd3
    } scan_state_t;

    localparam logic [31:0] BAD_DATA_DEF = 32'hDEAD_BEEF;

    localparam logic SRC_ROM = 1'b0;
    localparam logic SRC_RAM = 1'b1;

endpackage

// File: rtl/dbg_scan_timeout.sv
// Read-wait watchdog: reloads on clr, counts down while en, flags expire at terminal count.
module dbg_scan_timeout #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // Loaded with TIMEOUT-1 so that expire is high on the TIMEOUT-th enabled cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= CW'(TIMEOUT - 1);
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/dbg_mem_scanner.sv
// Sweeps ROM or RAM through the shared debug read port and publishes
// coherent address/data pairs for the VGA debug console.
//
// state | meaning
// IDLE  | no scan in progress; waits for frame_start or a pending restart
// REQ   | read request for word idx held on the debug port until granted
// WAIT  | granted, waiting for rvalid or watchdog expiry
// PUB   | MEM_Addr/MEM_Data just updated, scan_valid high
module dbg_mem_scanner
    import dbg_scan_pkg::*;
#(
    parameter int          ADDR_W   = 7,
    parameter int          TIMEOUT  = 15,
    parameter logic [31:0] BAD_DATA = BAD_DATA_DEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    input  logic        frame_start,
    input  logic        sel_ram,
    output logic        mem_req,
    output logic        mem_ram,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] MEM_Addr,
    output logic [31:0] MEM_Data,
    output logic        scan_valid,
    output logic        scan_done,
    output logic        busy
);

    scan_state_t       state, state_nxt;
    logic [ADDR_W-1:0] idx;
    logic              src;
    logic              pending;
    logic              abort_q;
    logic              start;
    logic              pub_load;
    logic [31:0]       pub_data;
    logic              tmo_clr;
    logic              tmo_expire;
    logic              idx_inc;
    logic              src_changed;
    logic              abort_now;
    logic              last_word;
    logic [31:0]       word_addr;

    assign word_addr   = {{(32-ADDR_W-2){1'b0}}, idx, 2'b00};
    assign last_word   = (idx == '1);
    assign src_changed = (sel_ram != src);
    assign abort_now   = abort_q | src_changed | ~enable;

    assign mem_req  = (state == REQ);
    assign mem_ram  = (state == REQ) & src;
    assign mem_addr = (state == REQ) ? word_addr : '0;
    assign busy     = (state != IDLE);

    dbg_scan_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk    (clk),
        .rstn   (rstn),
        .clr    (tmo_clr),
        .en     (state == WAIT),
        .expire (tmo_expire)
    );

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        pub_load  = 1'b0;
        pub_data  = mem_rdata;
        tmo_clr   = 1'b0;
        idx_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (enable && (frame_start || pending)) begin
                    state_nxt = REQ;
                    start     = 1'b1;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    tmo_clr = 1'b1;
                    if (mem_rvalid) begin
                        state_nxt = PUB;
                        pub_load  = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_nxt = PUB;
                    pub_load  = 1'b1;
                end else if (tmo_expire) begin
                    state_nxt = PUB;
                    pub_load  = 1'b1;
                    pub_data  = BAD_DATA;
                end
            end
            PUB: begin
                // Completing the last word wins over an abort so scan_done is never lost.
                if (last_word || abort_now) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = REQ;
                    idx_inc   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            idx        <= '0;
            src        <= SRC_ROM;
            pending    <= 1'b0;
            abort_q    <= 1'b0;
            MEM_Addr   <= '0;
            MEM_Data   <= '0;
            scan_valid <= 1'b0;
            scan_done  <= 1'b0;
        end else begin
            state      <= state_nxt;
            scan_valid <= pub_load;
            scan_done  <= pub_load & last_word;
            if (pub_load) begin
                MEM_Addr <= word_addr;
                MEM_Data <= pub_data;
            end
            if (start) begin
                src     <= sel_ram;
                idx     <= '0;
                pending <= 1'b0;
                abort_q <= 1'b0;
            end else begin
                if (idx_inc) begin
                    idx <= idx + 1'b1;
                end
                if (busy) begin
                    if (frame_start || src_changed) begin
                        pending <= 1'b1;
                    end
                    if (src_changed || !enable) begin
                        abort_q <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
